vdp_port: RTL and testbench
===========================

# vdp_port

CPU-side register and VRAM access port for the MSX video subsystem. It decodes TMS9918-style data-port and control-port accesses from the Z80 bus, keeps the VDP control registers and the auto-incrementing VRAM address, and drives the CPU port of the dual-port video RAM. It also exports the display mode and table base addresses consumed by the video timing/fetch stage. It runs entirely in the CPU clock domain.

## Interface
Parameters:
- RESET_R1, 8'h00: reset value of control register R1.

Ports:
- `clk`  in  1  CPU clock; the same clock drives the VRAM CPU port.
- `reset`  in  1  synchronous, active-high reset.
- `port_sel`  in  1  0 selects the data port (0x98), 1 selects the control port (0x99).
- `cpu_wr`  in  1  single-cycle write strobe.
- `cpu_rd`  in  1  single-cycle read strobe.
- `cpu_din`  in  8  CPU write data.
- `cpu_dout`  out  8  CPU read data, registered.
- `vram_addr`  out  14  VRAM CPU-port address.
- `vram_din`  out  8  VRAM write data.
- `vram_wr`  out  1  VRAM write enable, one cycle wide.
- `vram_dout`  in  8  VRAM read data; valid one clock after `vram_addr`.
- `vsync`  in  1  one-cycle end-of-active-frame pulse, already synchronised to `clk`.
- `mode`  out  2  display mode: 0 text, 1 Graphics I, 2 Graphics II, 3 multicolour.
- `name_table_addr`  out  14  {R2[3:0], 10'b0}.
- `font_addr`  out  14  {R4[2:0], 11'b0}.
- `int_n`  out  1  active-low interrupt.
- `busy`  out  1  high while a VRAM cycle is in progress.

## Operation
- State: `latch_full` flag, `latch` byte, 14-bit `addr`, 8-bit read-ahead `buffer`, registers R0–R7, frame flag F.
- Control write while `latch_full`=0: `latch` <= `cpu_din`, `latch_full` <= 1.
- Control write while `latch_full`=1: `latch_full` <= 0.
  - If `cpu_din[7]`=1, R[`cpu_din[2:0]`] <= `latch`.
  - Otherwise `addr` <= {`cpu_din[5:0]`, `latch`}. If `cpu_din[6]`=0 (read setup), a read-ahead fetch also starts.
- Data write: the VRAM write cycle stores `cpu_din` at `addr`. Then `buffer` <= `cpu_din` and `addr` increments. `latch_full` is cleared.
- Data read: `cpu_dout` <= `buffer`, then a read-ahead fetch starts. `latch_full` is cleared.
- Control read (status): `cpu_dout` <= {F, 7'b0}. F is cleared and `latch_full` is cleared.
- `addr` increments modulo 2^14 (3FFF → 0000).
- `mode` decoding: R1[4] (M1)=1 gives 0; else R0[1] (M3)=1 gives 2; else R1[3] (M2)=1 gives 3; else 1.
- `int_n` = ~(F & R1[5]).
- FSM states:
  - IDLE
  - WRITE: `vram_wr`=1, `vram_addr`=`addr`, `vram_din`=data → INC.
  - FETCH: `vram_addr`=`addr` → CAPTURE.
  - CAPTURE: `buffer` <= `vram_dout` → INC.
  - INC: `addr`++ → IDLE.
- Strobes that arrive when the FSM is not in IDLE are dropped. Control-port register/latch logic is not gated by the FSM. An address setup arriving during a fetch still updates `addr`, but its own read-ahead is dropped.
- A simultaneous `cpu_wr` and `cpu_rd` is treated as a write.

## Timing
- Reset values:
  - `cpu_dout` = 0, `vram_wr` = 0, `vram_addr` = 0, `vram_din` = 0.
  - `addr` = 0, `buffer` = 0, `latch_full` = 0.
  - R0 and R2–R7 = 0, R1 = RESET_R1.
  - F = 0, `int_n` = 1, `busy` = 0, FSM in IDLE.
  - With defaults: `mode` = 1, both table addresses = 0.
- A data write strobe at edge N produces `vram_wr` high during cycle N+1. `addr` has incremented by edge N+3. `busy` is high for 2 cycles.
- A read-ahead started at edge N presents the address during N+1, captures `buffer` at N+2 and increments at N+3. `busy` is high for 3 cycles.
- The CPU must space data-port accesses at least 4 clocks apart.
- A register write takes effect on `mode` and the table addresses one clock after the second control byte.
- `vsync` sets F on the same edge. If `vsync` and a status read coincide, the read returns the old F and F ends at 1 (set wins).
- Reset asserted mid-FSM returns to IDLE on that edge. A pending `vram_wr` is deasserted and not retried.

## Configuration
- `VDP_INT_EN` defined: F flag, the status bit and `int_n` behave as specified above.
- `VDP_INT_EN` undefined: no F flop. Status reads return 8'h00 and still clear `latch_full`. `int_n` is constant 1 and `vsync` is ignored.

## Test plan
- Reset, then control writes 0x10, 0x81 → R1=0x10 and `mode`=0. Control writes 0x02, 0x82 → `name_table_addr`=0x0800.
- Control writes 0x00, 0x40, then data writes 0xAA, 0x55 → VRAM writes 0xAA@0x0000 and 0x55@0x0001; `addr`=0x0002.
- Preload VRAM 0x1234=0x5A and 0x1235=0xC3, control writes 0x34, 0x12 → `buffer`=0x5A. Data reads return 0x5A then 0xC3.
- Setup write to 0x3FFF, two data writes → second write lands at 0x0000.
- R1=0x20, pulse `vsync` → `int_n`=0. Status read returns 0x80, `int_n`=1, and the next status read returns 0x00. Status read coinciding with `vsync` → F remains 1.
- Single control write 0x12, then a status read, then control writes 0x00, 0x40 → `addr`=0x0000 (the first byte was discarded), and no register was written.

Source files
------------

// File: rtl/vdp_port.sv
// CPU-side data/control port of the MSX VDP: register file, auto-incrementing VRAM address, VRAM CPU-port sequencer.
// Optional VDP_INT_EN: frame flag F, status bit 7 and int_n; when undefined status reads return 0 and int_n stays high.

// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for a data-port access or read setup
// S_WRITE   | vram_wr high, write data on vram_din
// S_FETCH   | read address presented to VRAM
// S_CAPTURE | VRAM read data loaded into the read-ahead buffer
// S_INC     | VRAM address post-increment
module vdp_port #(
   parameter logic [7:0] RESET_R1 = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        port_sel,
   input  logic        cpu_wr,
   input  logic        cpu_rd,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic [13:0] vram_addr,
   output logic [7:0]  vram_din,
   output logic        vram_wr,
   input  logic [7:0]  vram_dout,
   input  logic        vsync,
   output logic [1:0]  mode,
   output logic [13:0] name_table_addr,
   output logic [13:0] font_addr,
   output logic        int_n,
   output logic        busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WRITE   = 3'd1;
   localparam logic [2:0] S_FETCH   = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_INC     = 3'd4;

   logic [2:0]  r_state;
   logic        r_latch_full;
   logic [7:0]  r_latch;
   logic [13:0] r_addr;
   logic [7:0]  r_buffer;
   logic [7:0]  r_regs [8];

   logic        w_wr, w_rd, w_idle;
   logic        w_ctl_wr, w_ctl_rd, w_dat_wr, w_dat_rd;
   logic        w_setup, w_setup_fetch;
   logic [13:0] w_setup_addr;
   logic [7:0]  w_status;

   // A simultaneous write and read strobe is treated as a write.
   assign w_wr          = cpu_wr;
   assign w_rd          = cpu_rd & ~cpu_wr;
   assign w_idle        = (r_state == S_IDLE);
   assign w_ctl_wr      = w_wr & port_sel;
   assign w_ctl_rd      = w_rd & port_sel;
   assign w_dat_wr      = w_wr & ~port_sel & w_idle;
   assign w_dat_rd      = w_rd & ~port_sel & w_idle;
   assign w_setup       = w_ctl_wr & r_latch_full & ~cpu_din[7];
   assign w_setup_addr  = {cpu_din[5:0], r_latch};
   assign w_setup_fetch = w_setup & ~cpu_din[6] & w_idle;

`ifdef VDP_INT_EN
   logic r_f;

   // Set wins over the clear from a coincident status read.
   always_ff @(posedge clk) begin
      if (reset)         r_f <= 1'b0;
      else if (vsync)    r_f <= 1'b1;
      else if (w_ctl_rd) r_f <= 1'b0;
   end

   assign w_status = {r_f, 7'b0};
   assign int_n    = ~(r_f & r_regs[1][5]);
`else
   assign w_status = 8'h00;
   assign int_n    = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_latch_full <= 1'b0;
         r_latch      <= 8'h00;
         for (int i = 0; i < 8; i++) r_regs[i] <= (i == 1) ? RESET_R1 : 8'h00;
      end else if (w_ctl_wr) begin
         if (!r_latch_full) begin
            r_latch      <= cpu_din;
            r_latch_full <= 1'b1;
         end else begin
            r_latch_full <= 1'b0;
            if (cpu_din[7]) r_regs[cpu_din[2:0]] <= r_latch;
         end
      end else if (w_dat_wr || w_dat_rd || w_ctl_rd) begin
         r_latch_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)         cpu_dout <= 8'h00;
      else if (w_dat_rd) cpu_dout <= r_buffer;
      else if (w_ctl_rd) cpu_dout <= w_status;
   end

   // An address setup always lands, even mid-cycle; only its read-ahead is gated.
   always_ff @(posedge clk) begin
      if (reset)                 r_addr <= 14'd0;
      else if (w_setup)          r_addr <= w_setup_addr;
      else if (r_state == S_INC) r_addr <= r_addr + 14'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         vram_wr   <= 1'b0;
         vram_addr <= 14'd0;
         vram_din  <= 8'h00;
         r_buffer  <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_dat_wr) begin
                  vram_wr   <= 1'b1;
                  vram_addr <= r_addr;
                  vram_din  <= cpu_din;
                  r_state   <= S_WRITE;
               end else if (w_dat_rd) begin
                  vram_addr <= r_addr;
                  r_state   <= S_FETCH;
               end else if (w_setup_fetch) begin
                  vram_addr <= w_setup_addr;
                  r_state   <= S_FETCH;
               end
            end
            S_WRITE: begin
               vram_wr  <= 1'b0;
               r_buffer <= vram_din;
               r_state  <= S_INC;
            end
            S_FETCH:   r_state <= S_CAPTURE;
            S_CAPTURE: begin
               r_buffer <= vram_dout;
               r_state  <= S_INC;
            end
            S_INC:     r_state <= S_IDLE;
            default: begin
               vram_wr <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mode = 2'd1;
      if (r_regs[1][4])      mode = 2'd0;
      else if (r_regs[0][1]) mode = 2'd2;
      else if (r_regs[1][3]) mode = 2'd3;
   end

   assign name_table_addr = {r_regs[2][3:0], 10'b0};
   assign font_addr       = {r_regs[4][2:0], 11'b0};
   assign busy            = ~w_idle;

   logic w_unused;
   assign w_unused = ^{r_regs[0][7:2], r_regs[0][0], r_regs[1][7:6], r_regs[1][2:0],
                       r_regs[2][7:4], r_regs[3], r_regs[4][7:3], r_regs[5], r_regs[6], r_regs[7]
`ifndef VDP_INT_EN
                       , vsync, r_regs[1][5]
`endif
                      };

endmodule

// File: tb/tb_vdp_port.sv
// Directed bench for vdp_port: vector table for register/data accesses plus hand sequences for timing and corners.
// Interrupt expectations follow VDP_INT_EN the same way the design does.
module tb_vdp_port;

   logic        clk = 1'b0;
   logic        reset, port_sel, cpu_wr, cpu_rd, vsync;
   logic [7:0]  cpu_din, cpu_dout, vram_din, vram_dout;
   logic [13:0] vram_addr, name_table_addr, font_addr;
   logic        vram_wr, int_n, busy;
   logic [1:0]  mode;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  mem [16384];
   logic        pl_we = 1'b0;
   logic [13:0] pl_addr = '0;
   logic [7:0]  pl_data = '0;
   logic [21:0] wlog [$];

   always #5 clk = ~clk;

   vdp_port #(.RESET_R1(8'h00)) dut (
      .clk(clk), .reset(reset), .port_sel(port_sel), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
      .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_addr(vram_addr), .vram_din(vram_din),
      .vram_wr(vram_wr), .vram_dout(vram_dout), .vsync(vsync), .mode(mode),
      .name_table_addr(name_table_addr), .font_addr(font_addr), .int_n(int_n), .busy(busy)
   );

   // VRAM model: synchronous write, read data one clock after the address.
   always @(posedge clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (vram_wr) begin
         mem[vram_addr] <= vram_din;
         wlog.push_back({vram_addr, vram_din});
      end
      vram_dout <= mem[vram_addr];
   end

   typedef struct packed {
      logic        sel;
      logic        wr;
      logic        rd;
      logic [7:0]  din;
      logic        chk_dout;
      logic [7:0]  exp_dout;
      logic [1:0]  exp_mode;
      logic [13:0] exp_nt;
      logic [13:0] exp_font;
   } vec_t;

   vec_t vecs [27];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic access(input logic sel, input logic wr, input logic rd, input logic [7:0] din);
      @(negedge clk);
      port_sel = sel; cpu_wr = wr; cpu_rd = rd; cpu_din = din;
      @(posedge clk);
      #1;
      cpu_wr = 1'b0; cpu_rd = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [13:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic pulse_vsync();
      @(negedge clk);
      vsync = 1'b1;
      @(posedge clk);
      #1;
      vsync = 1'b0;
   endtask

   task automatic run_vec(input int i);
      access(vecs[i].sel, vecs[i].wr, vecs[i].rd, vecs[i].din);
      settle();
      if (vecs[i].chk_dout) chk($sformatf("vec%0d dout", i), {24'd0, cpu_dout}, {24'd0, vecs[i].exp_dout});
      chk($sformatf("vec%0d mode", i), {30'd0, mode}, {30'd0, vecs[i].exp_mode});
      chk($sformatf("vec%0d name_table", i), {18'd0, name_table_addr}, {18'd0, vecs[i].exp_nt});
      chk($sformatf("vec%0d font", i), {18'd0, font_addr}, {18'd0, vecs[i].exp_font});
   endtask

   initial begin
      reset = 1'b1; port_sel = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_din = 8'h00; vsync = 1'b0;
      for (int a = 0; a < 16384; a++) mem[a] = 8'h00;

      //            sel  wr    rd    din    chk   dout   mode  nt        font
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 2'd1, 14'h0000, 14'h0000};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, 2'd0, 14'h0000, 14'h0000};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 2'd0, 14'h0000, 14'h0000};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h82, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h0000};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h03, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h0000};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h84, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h1800};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h1800};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 2'd2, 14'h0800, 14'h1800};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'h08, 1'b0, 8'h00, 2'd2, 14'h0800, 14'h1800};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, 2'd2, 14'h0800, 14'h1800};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 14'h0800, 14'h1800};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00, 2'd3, 14'h0800, 14'h1800};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h18, 1'b0, 8'h00, 2'd3, 14'h0800, 14'h1800};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h1800};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 14'h0800, 14'h1800};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h81, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[19] = '{1'b1, 1'b1, 1'b0, 8'h40, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[20] = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[22] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[23] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 14'h0800, 14'h1800};
      vecs[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hAA, 2'd1, 14'h0800, 14'h1800};
      vecs[25] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h55, 2'd1, 14'h0800, 14'h1800};
      vecs[26] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 2'd1, 14'h0800, 14'h1800};

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst cpu_dout", {24'd0, cpu_dout}, 32'h0);
      chk("rst vram_wr", {31'd0, vram_wr}, 32'h0);
      chk("rst vram_addr", {18'd0, vram_addr}, 32'h0);
      chk("rst vram_din", {24'd0, vram_din}, 32'h0);
      chk("rst int_n", {31'd0, int_n}, 32'h1);
      chk("rst busy", {31'd0, busy}, 32'h0);
      chk("rst mode", {30'd0, mode}, 32'h1);
      chk("rst name_table", {18'd0, name_table_addr}, 32'h0);
      chk("rst font", {18'd0, font_addr}, 32'h0);

      for (int i = 0; i < 22; i++) run_vec(i);
      chk("wr count", wlog.size(), 32'd2);
      if (wlog.size() == 2) begin
         chk("wr0", {10'd0, wlog[0]}, {10'd0, 14'h0000, 8'hAA});
         chk("wr1", {10'd0, wlog[1]}, {10'd0, 14'h0001, 8'h55});
      end
      chk("addr after writes", {18'd0, dut.r_addr}, 32'h0002);
      for (int i = 22; i < 27; i++) run_vec(i);

      // read setup timing and read-ahead data
      preload(14'h1234, 8'h5A);
      preload(14'h1235, 8'hC3);
      access(1'b1, 1'b1, 1'b0, 8'h34);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h12);
      chk("fetch busy c1", {31'd0, busy}, 32'h1);
      chk("fetch vram_addr", {18'd0, vram_addr}, 32'h1234);
      @(posedge clk); #1;
      chk("fetch busy c2", {31'd0, busy}, 32'h1);
      @(posedge clk); #1;
      chk("fetch busy c3", {31'd0, busy}, 32'h1);
      chk("fetch buffer", {24'd0, dut.r_buffer}, 32'h5A);
      @(posedge clk); #1;
      chk("fetch busy done", {31'd0, busy}, 32'h0);
      settle();
      access(1'b0, 1'b0, 1'b1, 8'h00);
      settle();
      chk("read 1234", {24'd0, cpu_dout}, 32'h5A);
      access(1'b0, 1'b0, 1'b1, 8'h00);
      settle();
      chk("read 1235", {24'd0, cpu_dout}, 32'hC3);

      // write timing and address wrap
      wlog.delete();
      access(1'b1, 1'b1, 1'b0, 8'hFF);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h7F);
      settle();
      access(1'b0, 1'b1, 1'b0, 8'h11);
      chk("wr pulse on", {31'd0, vram_wr}, 32'h1);
      chk("wr busy c1", {31'd0, busy}, 32'h1);
      chk("wr vram_addr", {18'd0, vram_addr}, 32'h3FFF);
      @(posedge clk); #1;
      chk("wr pulse off", {31'd0, vram_wr}, 32'h0);
      chk("wr busy c2", {31'd0, busy}, 32'h1);
      @(posedge clk); #1;
      chk("wr busy done", {31'd0, busy}, 32'h0);
      settle();
      access(1'b0, 1'b1, 1'b0, 8'h22);
      settle();
      chk("wrap count", wlog.size(), 32'd2);
      if (wlog.size() == 2) chk("wrap second", {10'd0, wlog[1]}, {10'd0, 14'h0000, 8'h22});

      // strobe during busy is dropped
      wlog.delete();
      access(1'b1, 1'b1, 1'b0, 8'h00);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h42);
      settle();
      access(1'b0, 1'b1, 1'b0, 8'h33);
      access(1'b0, 1'b1, 1'b0, 8'h44);
      settle();
      access(1'b0, 1'b1, 1'b0, 8'h66);
      settle();
      chk("drop count", wlog.size(), 32'd2);
      if (wlog.size() == 2) begin
         chk("drop first", {10'd0, wlog[0]}, {10'd0, 14'h0200, 8'h33});
         chk("drop next", {10'd0, wlog[1]}, {10'd0, 14'h0201, 8'h66});
      end

      // interrupt flag
      access(1'b1, 1'b1, 1'b0, 8'h20);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h81);
      settle();
      pulse_vsync();
`ifdef VDP_INT_EN
      chk("int after vsync", {31'd0, int_n}, 32'h0);
      access(1'b1, 1'b0, 1'b1, 8'h00);
      chk("status F", {24'd0, cpu_dout}, 32'h80);
      chk("int cleared", {31'd0, int_n}, 32'h1);
      access(1'b1, 1'b0, 1'b1, 8'h00);
      chk("status clear", {24'd0, cpu_dout}, 32'h00);
      @(negedge clk);
      vsync = 1'b1; port_sel = 1'b1; cpu_rd = 1'b1;
      @(posedge clk); #1;
      vsync = 1'b0; cpu_rd = 1'b0;
      chk("coincide old F", {24'd0, cpu_dout}, 32'h00);
      chk("coincide int", {31'd0, int_n}, 32'h0);
      access(1'b1, 1'b0, 1'b1, 8'h00);
      chk("coincide F kept", {24'd0, cpu_dout}, 32'h80);
`else
      chk("int after vsync", {31'd0, int_n}, 32'h1);
      access(1'b1, 1'b0, 1'b1, 8'h00);
      chk("status F", {24'd0, cpu_dout}, 32'h00);
      chk("int stays", {31'd0, int_n}, 32'h1);
`endif

      // half-written address is discarded by a status read
      wlog.delete();
      access(1'b1, 1'b1, 1'b0, 8'h12);
      settle();
      access(1'b1, 1'b0, 1'b1, 8'h00);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h00);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h40);
      settle();
      chk("discard addr", {18'd0, dut.r_addr}, 32'h0000);
      chk("discard mode", {30'd0, mode}, 32'h1);
      chk("discard nt", {18'd0, name_table_addr}, 32'h0800);
      chk("discard font", {18'd0, font_addr}, 32'h1800);
      access(1'b0, 1'b1, 1'b0, 8'h77);
      settle();
      chk("discard wr count", wlog.size(), 32'd1);
      if (wlog.size() == 1) chk("discard wr", {10'd0, wlog[0]}, {10'd0, 14'h0000, 8'h77});

      // reset in the middle of a write cycle
      access(1'b1, 1'b1, 1'b0, 8'h00);
      settle();
      access(1'b1, 1'b1, 1'b0, 8'h41);
      settle();
      access(1'b0, 1'b1, 1'b0, 8'h99);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst vram_wr", {31'd0, vram_wr}, 32'h0);
      chk("midrst busy", {31'd0, busy}, 32'h0);
      chk("midrst vram_addr", {18'd0, vram_addr}, 32'h0);
      chk("midrst mode", {30'd0, mode}, 32'h1);
      chk("midrst nt", {18'd0, name_table_addr}, 32'h0);
      reset = 1'b0;
      wlog.delete();
      settle();
      chk("midrst no retry", wlog.size(), 32'd0);
      chk("midrst addr", {18'd0, dut.r_addr}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
